// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port 256x8 RAM between CPU and DMA with round-robin and a bounded DMA burst lock.
// Ports:
//   Clk, Rst_n                         clock, synchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt    CPU request side, combinational grant
//   cpu_rvalid/cpu_rdata                CPU read return, two cycles after accept
//   dma_req/we/lock/addr/wdata, dma_gnt DMA request side with burst lock
//   dma_rvalid/dma_rdata                DMA read return
//   ram_cs/we/addr/wdata                registered RAM command
//   ram_rdata                           RAM read data, one cycle after a read command
module ram_arbiter #(
    parameter int MAX_LOCK = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    input  logic       dma_req,
    input  logic       dma_we,
    input  logic       dma_lock,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic       dma_rvalid,
    output logic [7:0] dma_rdata,
    output logic       ram_cs,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);
    typedef enum logic {ARB, DMA_LOCKED} state_t;
    state_t state_q, state_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic last_dma_q, last_dma_d;
    logic cs_q, cs_d, we_q, we_d, own1_q, own1_d, rv_q, rv_d, own2_q, own2_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic rr_cpu, rr_dma, locked, starve, cpu_acc, dma_acc;
    always_comb begin
        rr_cpu = cpu_req && (!dma_req || last_dma_q);
        rr_dma = dma_req && !rr_cpu;
        // Lock only holds while the DMA keeps dma_lock high; a release falls back to round-robin the same cycle.
        locked = state_q == DMA_LOCKED && dma_lock;
        starve = lock_cnt_q == LOCK_MAX && cpu_req;
        dma_gnt = Rst_n && (locked ? dma_req && !starve : rr_dma);
        cpu_gnt = Rst_n && (locked ? cpu_req && (!dma_req || starve) : rr_cpu);
        cpu_acc = cpu_req && cpu_gnt;
        dma_acc = dma_req && dma_gnt;
        last_dma_d = dma_acc ? 1'b1 : cpu_acc ? 1'b0 : last_dma_q;
        state_d = !locked ? ((dma_acc && dma_lock) ? DMA_LOCKED : ARB) : DMA_LOCKED;
        lock_cnt_d = !locked ? LW'(dma_acc && dma_lock)
                   : starve ? '0
                   : (dma_acc && lock_cnt_q != LOCK_MAX) ? lock_cnt_q + LW'(1) : lock_cnt_q;
        cs_d = cpu_acc || dma_acc;
        own1_d = dma_acc;
        we_d = dma_acc ? dma_we : cpu_acc ? cpu_we : we_q;
        addr_d = dma_acc ? dma_addr : cpu_acc ? cpu_addr : addr_q;
        wdata_d = dma_acc ? dma_wdata : cpu_acc ? cpu_wdata : wdata_q;
        rv_d = cs_q && !we_q;
        own2_d = own1_q;
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ARB;
            lock_cnt_q <= '0;
            last_dma_q <= 1'b1;
            cs_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            own1_q <= 1'b0;
            rv_q <= 1'b0;
            own2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_dma_q <= last_dma_d;
            cs_q <= cs_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            own1_q <= own1_d;
            rv_q <= rv_d;
            own2_q <= own2_d;
        end
    end
    assign ram_cs = cs_q;
    assign ram_we = we_q;
    assign ram_addr = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_rvalid = rv_q && !own2_q;
    assign dma_rvalid = rv_q && own2_q;
    assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;
    assign dma_rdata = dma_rvalid ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed check of ram_arbiter against a behavioural model and a RAM model.
module tb_ram_arbiter;
    localparam int MAXL = 16;
    logic clk, rst_n;
    logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [7:0] dma_addr, dma_wdata, dma_rdata;
    logic ram_cs, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    int errors = 0, checks = 0;
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic eg_c, eg_d, m_last_dma, m_locked;
    int m_cnt;
    logic exp_cs, exp_we, exp_own, ev_rv, ev_own;
    logic [7:0] exp_addr, exp_wdata, exp_rd, ev_data;

    ram_arbiter #(.MAX_LOCK(MAXL)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // RAM macro model: synchronous write, registered read data, garbage when no read
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= (ram_cs && !ram_we) ? mem[ram_addr] : 8'($urandom);
        end
    end

    task automatic model_reset();
        m_last_dma = 1'b1; m_locked = 1'b0; m_cnt = 0;
        exp_cs = 1'b0; exp_we = 1'b0; exp_addr = 8'h00; exp_wdata = 8'h00; exp_own = 1'b0; exp_rd = 8'h00;
        ev_rv = 1'b0; ev_own = 1'b0; ev_data = 8'h00;
    endtask

    // Compare process: predicts grants from the arbitration rules and the expected RAM/return pipeline
    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            eg_c = 1'b0; eg_d = 1'b0;
            if (rst_n) begin
                if (m_locked && dma_lock) begin
                    if (cpu_req && m_cnt == MAXL) eg_c = 1'b1;
                    else if (dma_req) eg_d = 1'b1;
                    else eg_c = cpu_req;
                end else if (cpu_req && dma_req) begin
                    eg_c = m_last_dma; eg_d = !m_last_dma;
                end else begin
                    eg_c = cpu_req; eg_d = dma_req;
                end
            end
            chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
            chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
            chk("ram_cs", 32'(ram_cs), 32'(exp_cs));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_rv && !ev_own));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(ev_rv && ev_own));
            if (ev_rv) chk("rdata", 32'(ev_own ? dma_rdata : cpu_rdata), 32'(ev_data));
            if (!rst_n) model_reset();
            else begin
                ev_rv = exp_cs && !exp_we; ev_own = exp_own; ev_data = exp_rd;
                if (eg_c || eg_d) begin
                    exp_cs = 1'b1; exp_own = eg_d;
                    exp_we = eg_d ? dma_we : cpu_we;
                    exp_addr = eg_d ? dma_addr : cpu_addr;
                    exp_wdata = eg_d ? dma_wdata : cpu_wdata;
                    exp_rd = shadow[exp_addr];
                    if (exp_we) shadow[exp_addr] = exp_wdata;
                    m_last_dma = eg_d;
                end else exp_cs = 1'b0;
                if (m_locked && !dma_lock) begin
                    m_locked = 1'b0; m_cnt = 0;
                end else if (m_locked) begin
                    if (eg_c && m_cnt == MAXL) m_cnt = 0;
                    else if (eg_d && m_cnt < MAXL) m_cnt++;
                end else if (eg_d && dma_lock) begin
                    m_locked = 1'b1; m_cnt = 1;
                end
            end
        end
    end

    // Applies inputs just after a rising edge and returns at the following falling edge
    task automatic drive(input logic r, input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                         input logic dr, input logic dw, input logic dl, input logic [7:0] da, input logic [7:0] dd);
        @(posedge clk);
        #1;
        rst_n = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] cg, dg, crv, drv;
        logic [31:0] cseq;
        int dn, n, cyc;
        logic lk, r;
        rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
            if (i > 0) begin
                chk("rst_gnt", 32'({cpu_gnt, dma_gnt}), 32'd0);
                chk("rst_cs_rv", 32'({ram_cs, cpu_rvalid, dma_rvalid}), 32'd0);
            end
        end
        drive(1, 1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
        chk("first_gnt", 32'({cpu_gnt, dma_gnt}), 32'b10);
        do_reset();
        drive(1, 1, 1, 8'h40, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
        chk("wr_gnt", 32'(cpu_gnt), 32'd1);
        drive(1, 1, 0, 8'h40, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        chk("wr_cmd", 32'({ram_cs, ram_we, ram_addr, ram_wdata}), 32'h3_40A5);
        idle();
        chk("rd_cmd", 32'({ram_cs, ram_we, ram_addr}), 32'h240);
        chk("rd_early", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        idle();
        chk("rd_ret", 32'({cpu_rvalid, dma_rvalid, cpu_rdata}), 32'h2A5);
        idle();
        chk("rd_once", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        do_reset();
        cg = 0; dg = 0; crv = 0; drv = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(1, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
            else idle();
            cg[i] = cpu_gnt; dg[i] = dma_gnt; crv[i] = cpu_rvalid; drv[i] = dma_rvalid;
        end
        chk("rr_cpu_gnt", 32'(cg), 32'h15);
        chk("rr_dma_gnt", 32'(dg), 32'h2A);
        chk("rr_cpu_rv", 32'(crv), 32'h54);
        chk("rr_dma_rv", 32'(drv), 32'hA8);
        do_reset();
        drive(1, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        dn = 0; n = 0; cyc = 0; cseq = 0;
        while (dn < 20 && cyc < 40) begin
            drive(1, 1, 0, 8'h30, 8'h00, 1, 0, 1, 8'(dn), 8'h00);
            if (cpu_gnt) begin cseq[n] = 1'b1; n++; end
            else if (dma_gnt) begin n++; dn++; end
            cyc++;
        end
        chk("burst_dma", 32'(dn), 32'd20);
        chk("burst_n", 32'(n), 32'd21);
        chk("burst_cpu_slot", cseq, 32'h0001_0000);
        idle();
        do_reset();
        drive(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h03, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h04, 8'h00);
        drive(1, 1, 0, 8'h11, 8'h00, 1, 0, 0, 8'h05, 8'h00);
        chk("release_cpu", 32'({cpu_gnt, dma_gnt}), 32'b10);
        drive(1, 1, 0, 8'h11, 8'h00, 1, 0, 0, 8'h05, 8'h00);
        chk("release_rr", 32'({cpu_gnt, dma_gnt}), 32'b01);
        drive(1, 1, 0, 8'h11, 8'h00, 1, 0, 1, 8'h05, 8'h00);
        chk("release_arb", 32'({cpu_gnt, dma_gnt}), 32'b10);
        idle();
        do_reset();
        drive(1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00);
        chk("mid_rst_cs", 32'(ram_cs), 32'd1);
        idle();
        chk("mid_rst_n2", 32'({ram_cs, cpu_rvalid, dma_rvalid}), 32'd0);
        idle();
        chk("mid_rst_n3", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        lk = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) lk = !lk;
            r = $urandom_range(0, 199) != 0;
            drive(r, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)), 8'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, lk, 8'($urandom_range(0, 15)), 8'($urandom));
        end
        idle();
        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
